// File: rtl/m68k_bus_seq.sv
// 68010-style bus-cycle sequencer: turns one CPU transfer request into an
// AS/UDS/LDS/R_W handshake, terminated by DTACK, BERR or a watchdog timeout.
module m68k_bus_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk40,
  input  logic        reset_n,
  input  logic        req,
  output logic        ready,
  input  logic [23:0] req_addr,
  input  logic [2:0]  req_fc,
  input  logic        req_rw,
  input  logic        req_byte,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        berr,
  output logic        aerr,
  output logic [22:0] a,
  output logic [2:0]  fc,
  output logic        as_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic        rw,
  output logic [15:0] d_out,
  output logic        d_oe,
  input  logic [15:0] d_in,
  input  logic        dtack_n,
  input  logic        berr_n
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ASRT, S_DATA, S_STRB, S_WAIT, S_LATCH, S_END
  } state_e;

  state_e          state_q;
  logic            ready_q, done_q, berr_q, aerr_q;
  logic [15:0]     rdata_q, d_out_q, wdata_q;
  logic [22:0]     a_q;
  logic [2:0]      fc_q;
  logic            as_n_q, uds_n_q, lds_n_q, rw_q, d_oe_q;
  logic            uds_en_q, lds_en_q;
  logic [WD_W-1:0] wd_q, wd_d;

  always_comb wd_d = wd_q + WD_W'(1);

  // Each case arm sets the outputs that become visible in the *next* state.
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      berr_q   <= 1'b0;
      aerr_q   <= 1'b0;
      rdata_q  <= '0;
      d_out_q  <= '0;
      wdata_q  <= '0;
      a_q      <= '0;
      fc_q     <= '0;
      as_n_q   <= 1'b1;
      uds_n_q  <= 1'b1;
      lds_n_q  <= 1'b1;
      rw_q     <= 1'b1;
      d_oe_q   <= 1'b0;
      uds_en_q <= 1'b0;
      lds_en_q <= 1'b0;
      wd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            ready_q <= 1'b0;
            if (!req_byte && req_addr[0]) begin
              done_q  <= 1'b1;
              aerr_q  <= 1'b1;
              berr_q  <= 1'b0;
              state_q <= S_END;
            end else begin
              a_q      <= req_addr[23:1];
              fc_q     <= req_fc;
              rw_q     <= req_rw;
              uds_en_q <= !req_byte || !req_addr[0];
              lds_en_q <= !req_byte ||  req_addr[0];
              wdata_q  <= req_byte ? {2{req_wdata[7:0]}} : req_wdata;
              state_q  <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          as_n_q <= 1'b0;
          if (rw_q) begin
            uds_n_q <= !uds_en_q;
            lds_n_q <= !lds_en_q;
          end
          state_q <= S_ASRT;
        end
        S_ASRT: begin
          if (rw_q) begin
            wd_q    <= '0;
            state_q <= S_WAIT;
          end else begin
            d_oe_q  <= 1'b1;
            d_out_q <= wdata_q;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          uds_n_q <= !uds_en_q;
          lds_n_q <= !lds_en_q;
          state_q <= S_STRB;
        end
        S_STRB: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!berr_n || (dtack_n && wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
            as_n_q  <= 1'b1;
            uds_n_q <= 1'b1;
            lds_n_q <= 1'b1;
            done_q  <= 1'b1;
            berr_q  <= 1'b1;
            aerr_q  <= 1'b0;
            state_q <= S_END;
          end else if (!dtack_n) begin
            state_q <= S_LATCH;
          end else begin
            wd_q <= wd_d;
          end
        end
        S_LATCH: begin
          if (rw_q) rdata_q <= d_in;
          as_n_q  <= 1'b1;
          uds_n_q <= 1'b1;
          lds_n_q <= 1'b1;
          done_q  <= 1'b1;
          berr_q  <= 1'b0;
          aerr_q  <= 1'b0;
          state_q <= S_END;
        end
        S_END: begin
          ready_q <= 1'b1;
          d_oe_q  <= 1'b0;
          rw_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign berr  = berr_q;
  assign aerr  = aerr_q;
  assign a     = a_q;
  assign fc    = fc_q;
  assign as_n  = as_n_q;
  assign uds_n = uds_n_q;
  assign lds_n = lds_n_q;
  assign rw    = rw_q;
  assign d_out = d_out_q;
  assign d_oe  = d_oe_q;

endmodule

// File: tb/tb_m68k_bus_seq.sv
// Directed bench for m68k_bus_seq: cycle-exact handshake timing, lanes,
// wait states, timeout, address error, BERR priority and async reset.
module tb_m68k_bus_seq;

  logic        clk40 = 1'b0;
  logic        reset_n;
  logic        req;
  logic        ready;
  logic [23:0] req_addr;
  logic [2:0]  req_fc;
  logic        req_rw;
  logic        req_byte;
  logic [15:0] req_wdata;
  logic        done;
  logic [15:0] rdata;
  logic        berr;
  logic        aerr;
  logic [22:0] a;
  logic [2:0]  fc;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic [15:0] d_out;
  logic        d_oe;
  logic [15:0] d_in;
  logic        dtack_n;
  logic        berr_n;

  int n_checks = 0;
  int n_pass   = 0;

  // Edge indices are counted from the accepting edge (k=0); the sample taken
  // after edge k corresponds to bus cycle t+k+1.
  int r_done_k, r_as_first, r_as_last, r_oe_first, r_oe_last, r_uds_lo, r_lds_lo;
  logic        r_rw, r_as_n, r_uds_n, r_lds_n;
  logic [22:0] r_a;
  logic [2:0]  r_fc;
  logic [15:0] r_dout;

  m68k_bus_seq #(.TIMEOUT_CYCLES(64)) dut (
    .clk40(clk40), .reset_n(reset_n), .req(req), .ready(ready),
    .req_addr(req_addr), .req_fc(req_fc), .req_rw(req_rw), .req_byte(req_byte),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .berr(berr), .aerr(aerr),
    .a(a), .fc(fc), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .dtack_n(dtack_n), .berr_n(berr_n)
  );

  always #5 clk40 = ~clk40;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic run_txn(input logic [23:0] addr, input logic [2:0] f, input logic rd,
                         input logic byt, input logic [15:0] wd,
                         input int dtack_at, input int berr_at);
    r_done_k = -1; r_as_first = -1; r_as_last = -1; r_oe_first = -1; r_oe_last = -1;
    r_uds_lo = 0; r_lds_lo = 0;
    @(negedge clk40);
    dtack_n = (dtack_at < 0) ? 1'b0 : 1'b1;
    berr_n  = (berr_at  < 0) ? 1'b0 : 1'b1;
    req = 1'b1; req_addr = addr; req_fc = f; req_rw = rd; req_byte = byt; req_wdata = wd;
    @(posedge clk40); #1;
    req = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!as_n) begin
        if (r_as_first < 0) r_as_first = k;
        r_as_last = k;
      end
      if (d_oe) begin
        if (r_oe_first < 0) r_oe_first = k;
        r_oe_last = k;
      end
      if (!uds_n) r_uds_lo++;
      if (!lds_n) r_lds_lo++;
      if (done) begin
        r_done_k = k;
        r_rw = rw; r_as_n = as_n; r_uds_n = uds_n; r_lds_n = lds_n;
        r_a = a; r_fc = fc; r_dout = d_out;
        break;
      end
      if (k == dtack_at) dtack_n = 1'b0;
      if (k == berr_at)  berr_n  = 1'b0;
      @(posedge clk40); #1;
    end
    @(posedge clk40); #1;
    check("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = 1'b0; req_addr = '0; req_fc = '0; req_rw = 1'b1;
    req_byte = 1'b0; req_wdata = '0; d_in = '0; dtack_n = 1'b1; berr_n = 1'b1;
    #23;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_as_n",  32'({as_n, uds_n, lds_n, rw}), 32'hF);
    check("rst_d_oe",  32'(d_oe),  32'd0);
    check("rst_a",     32'(a),     32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk40); reset_n = 1'b1;

    // Zero-wait word read: AS low t+2..t+4, done t+5
    d_in = 16'h1234;
    run_txn(24'h000000, 3'd6, 1'b1, 1'b0, 16'h0, -1, 1000);
    check("rd_done_k", 32'(r_done_k), 32'd4);
    check("rd_as_first", 32'(r_as_first), 32'd1);
    check("rd_as_last", 32'(r_as_last), 32'd3);
    check("rd_uds_lo", 32'(r_uds_lo), 32'd3);
    check("rd_lds_lo", 32'(r_lds_lo), 32'd3);
    check("rd_rdata", 32'(rdata), 32'h1234);
    check("rd_berr", 32'({berr, aerr}), 32'd0);
    check("rd_fc", 32'(r_fc), 32'd6);
    check("rd_oe", 32'(r_oe_first), 32'hFFFF_FFFF);

    // Byte write to odd address: LDS only, data replicated, d_oe t+3..t+7
    run_txn(24'h00000F, 3'd5, 1'b0, 1'b1, 16'h00A5, -1, 1000);
    check("wr_done_k", 32'(r_done_k), 32'd6);
    check("wr_a", 32'(r_a), 32'h000007);
    check("wr_as", 32'({r_as_first[7:0], r_as_last[7:0]}), 32'h0105);
    check("wr_uds_lo", 32'(r_uds_lo), 32'd0);
    check("wr_lds_lo", 32'(r_lds_lo), 32'd3);
    check("wr_oe", 32'({r_oe_first[7:0], r_oe_last[7:0]}), 32'h0206);
    check("wr_dout", 32'(r_dout), 32'hA5A5);
    check("wr_rw", 32'(r_rw), 32'd0);
    check("wr_rdata_keep", 32'(rdata), 32'h1234);
    check("wr_rw_idle", 32'({rw, d_oe}), 32'b10);

    // Ten wait states: done exactly 10 cycles later, strobes held
    d_in = 16'hBEEF;
    run_txn(24'h000002, 3'd1, 1'b1, 1'b0, 16'h0, 12, 1000);
    check("dly_done_k", 32'(r_done_k), 32'd14);
    check("dly_as_last", 32'(r_as_last), 32'd13);
    check("dly_strobes", 32'({r_uds_lo[7:0], r_lds_lo[7:0]}), 32'h0D0D);
    check("dly_rdata", 32'(rdata), 32'hBEEF);

    // No DTACK: 64 WAIT cycles then forced bus error
    d_in = 16'h1111;
    run_txn(24'h000004, 3'd2, 1'b1, 1'b0, 16'h0, 1000, 1000);
    check("to_done_k", 32'(r_done_k), 32'd66);
    check("to_berr", 32'({berr, aerr}), 32'b10);
    check("to_strobes_end", 32'({r_as_n, r_uds_n, r_lds_n}), 32'b111);
    check("to_rdata_keep", 32'(rdata), 32'hBEEF);

    // Misaligned word: no bus activity, done next cycle, aerr
    run_txn(24'h000005, 3'd1, 1'b1, 1'b0, 16'h0, -1, 1000);
    check("ae_done_k", 32'(r_done_k), 32'd0);
    check("ae_flags", 32'({berr, aerr}), 32'b01);
    check("ae_as", 32'(r_as_first), 32'hFFFF_FFFF);
    check("ae_rdata_keep", 32'(rdata), 32'hBEEF);

    // BERR and DTACK together: BERR wins
    d_in = 16'h2222;
    run_txn(24'h000008, 3'd1, 1'b1, 1'b0, 16'h0, -1, -1);
    check("be_done_k", 32'(r_done_k), 32'd3);
    check("be_flags", 32'({berr, aerr}), 32'b10);
    check("be_rdata_keep", 32'(rdata), 32'hBEEF);

    // Byte read at even address: UDS only, full 16-bit capture
    d_in = 16'h3344;
    run_txn(24'h00000A, 3'd1, 1'b1, 1'b1, 16'h0, -1, 1000);
    check("br_done_k", 32'(r_done_k), 32'd4);
    check("br_lanes", 32'({r_uds_lo[7:0], r_lds_lo[7:0]}), 32'h0300);
    check("br_rdata", 32'(rdata), 32'h3344);

    // Async reset in WAIT of a write
    @(negedge clk40);
    dtack_n = 1'b1; berr_n = 1'b1;
    req = 1'b1; req_addr = 24'h000010; req_rw = 1'b0; req_byte = 1'b0; req_wdata = 16'h5555;
    @(posedge clk40); #1; req = 1'b0;
    repeat (5) @(posedge clk40);
    #2;
    check("mr_pre_as", 32'({as_n, d_oe}), 32'b01);
    reset_n = 1'b0;
    #1;
    check("mr_strobes", 32'({as_n, uds_n, lds_n}), 32'b111);
    check("mr_d_oe", 32'(d_oe), 32'd0);
    check("mr_ready", 32'(ready), 32'd1);
    check("mr_done", 32'(done), 32'd0);
    @(negedge clk40); reset_n = 1'b1;
    begin
      int dn = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk40); #1;
        if (done) dn++;
      end
      check("mr_no_done", 32'(dn), 32'd0);
    end
    check("mr_rdata", 32'(rdata), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
